// File: rtl/watch_pkg.sv
// Shared time-field constants, widths and helpers for the watch datapath.
// The display and set-mode blocks use these same definitions.
package watch_pkg;

   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned MIN_MAX = 59;

   localparam int unsigned HOUR_W = 5;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned SEC_W  = 6;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
      logic [SEC_W-1:0]  sec;
   } hms_t;

   // Saturate a user-supplied field value to its legal maximum.
   function automatic int unsigned clamp_field(input int unsigned val,
                                               input int unsigned max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/watch_time_counter_if.sv
// Tick/control inputs and time/strobe outputs of the watch time counter.
// The master side is the tick generator plus control; the slave is the counter.
interface watch_time_counter_if #(
   parameter int unsigned TICK_HZ = 1000
);
   import watch_pkg::*;

   localparam int unsigned SUB_W = $clog2(TICK_HZ);

   logic              i_tick;
   logic              i_run;
   logic              i_down;
   logic              i_clear;
   logic              i_load;
   logic [HOUR_W-1:0] i_hour_val;
   logic [MIN_W-1:0]  i_min_val;
   logic [SEC_W-1:0]  i_sec_val;

   logic [HOUR_W-1:0] o_hour;
   logic [MIN_W-1:0]  o_min;
   logic [SEC_W-1:0]  o_sec;
   logic [SUB_W-1:0]  o_sub;
   logic              o_sec_pulse;
   logic              o_min_pulse;
   logic              o_expired;
   logic              o_load_err;

   modport master (
      output i_tick, i_run, i_down, i_clear, i_load,
      output i_hour_val, i_min_val, i_sec_val,
      input  o_hour, o_min, o_sec, o_sub,
      input  o_sec_pulse, o_min_pulse, o_expired, o_load_err
   );

   modport slave (
      input  i_tick, i_run, i_down, i_clear, i_load,
      input  i_hour_val, i_min_val, i_sec_val,
      output o_hour, o_min, o_sec, o_sub,
      output o_sec_pulse, o_min_pulse, o_expired, o_load_err
   );

endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with synchronous clear/load and wrap strobes.
// Chained through carry_out/borrow_out to build multi-digit time counters.
module mod_n_updown_counter #(
   parameter int unsigned N = 10,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         down,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         carry_out,
   output logic         borrow_out
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   // Wrap strobes are combinational so the next stage advances in the same cycle.
   assign carry_out  = en && !down && (value == LAST);
   assign borrow_out = en &&  down && (value == '0);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (en) begin
         if (down) begin
            value <= (value == '0) ? LAST : value - W'(1);
         end else begin
            value <= (value == LAST) ? '0 : value + W'(1);
         end
      end
   end

endmodule

// File: rtl/watch_time_counter.sv
// Hours:minutes:seconds.sub time counter driven by the periodic tick pulse.
// Handles clear/load/tick priority, load clamping, zero-hold and expiry.
module watch_time_counter
   import watch_pkg::*;
#(
   parameter int unsigned TICK_HZ  = 1000,
   parameter int unsigned HOUR_MAX = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   watch_time_counter_if.slave  bus
);

   localparam int unsigned SUB_W = $clog2(TICK_HZ);

   hms_t load_hms;
   logic load_range_err;

   logic upper_zero;
   logic all_zero;
   logic ends_at_zero;
   logic count_en;

   logic sub_carry, sub_borrow, sub_wrap;
   logic sec_carry, sec_borrow, sec_wrap;
   logic min_carry, min_borrow, min_wrap;
   logic hour_carry_unused, hour_borrow_unused;

   assign load_hms.hour = HOUR_W'(clamp_field(32'(bus.i_hour_val), HOUR_MAX));
   assign load_hms.min  = MIN_W'(clamp_field(32'(bus.i_min_val), MIN_MAX));
   assign load_hms.sec  = SEC_W'(clamp_field(32'(bus.i_sec_val), SEC_MAX));

   assign load_range_err = (32'(bus.i_hour_val) > HOUR_MAX) ||
                           (32'(bus.i_min_val)  > MIN_MAX)  ||
                           (32'(bus.i_sec_val)  > SEC_MAX);

   assign upper_zero = (bus.o_hour == '0) && (bus.o_min == '0) && (bus.o_sec == '0);
   assign all_zero   = upper_zero && (bus.o_sub == '0);

   // A down-count sitting at zero holds rather than wrapping to the day maximum.
   assign count_en = bus.i_tick && bus.i_run && !bus.i_clear && !bus.i_load &&
                     !(bus.i_down && all_zero);

   // Exactly one sub unit left: this decrement lands on all-zero.
   assign ends_at_zero = bus.i_down && upper_zero && (bus.o_sub == SUB_W'(1));

   assign sub_wrap = sub_carry || sub_borrow;
   assign sec_wrap = sec_carry || sec_borrow;
   assign min_wrap = min_carry || min_borrow;

   mod_n_updown_counter #(.N(TICK_HZ), .W(SUB_W)) u_sub (
      .clk        (clk),
      .reset      (reset),
      .en         (count_en),
      .down       (bus.i_down),
      .clear      (bus.i_clear),
      .load       (bus.i_load),
      .load_val   ('0),
      .value      (bus.o_sub),
      .carry_out  (sub_carry),
      .borrow_out (sub_borrow)
   );

   mod_n_updown_counter #(.N(SEC_MAX + 1), .W(SEC_W)) u_sec (
      .clk        (clk),
      .reset      (reset),
      .en         (sub_wrap),
      .down       (bus.i_down),
      .clear      (bus.i_clear),
      .load       (bus.i_load),
      .load_val   (load_hms.sec),
      .value      (bus.o_sec),
      .carry_out  (sec_carry),
      .borrow_out (sec_borrow)
   );

   mod_n_updown_counter #(.N(MIN_MAX + 1), .W(MIN_W)) u_min (
      .clk        (clk),
      .reset      (reset),
      .en         (sec_wrap),
      .down       (bus.i_down),
      .clear      (bus.i_clear),
      .load       (bus.i_load),
      .load_val   (load_hms.min),
      .value      (bus.o_min),
      .carry_out  (min_carry),
      .borrow_out (min_borrow)
   );

   mod_n_updown_counter #(.N(HOUR_MAX + 1), .W(HOUR_W)) u_hour (
      .clk        (clk),
      .reset      (reset),
      .en         (min_wrap),
      .down       (bus.i_down),
      .clear      (bus.i_clear),
      .load       (bus.i_load),
      .load_val   (load_hms.hour),
      .value      (bus.o_hour),
      .carry_out  (hour_carry_unused),
      .borrow_out (hour_borrow_unused)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.o_sec_pulse <= 1'b0;
         bus.o_min_pulse <= 1'b0;
         bus.o_expired   <= 1'b0;
         bus.o_load_err  <= 1'b0;
      end else begin
         bus.o_sec_pulse <= sub_wrap;
         bus.o_min_pulse <= sec_wrap;
         bus.o_expired   <= count_en && ends_at_zero;
         bus.o_load_err  <= bus.i_load && !bus.i_clear && load_range_err;
      end
   end

endmodule

// File: tb/tb_watch_time_counter.sv
// Scoreboard bench for watch_time_counter: a linear-time reference model pushes
// the expected output word per driven cycle; it is popped after the clock edge.
module tb_watch_time_counter;
   import watch_pkg::*;

   localparam int TICK_HZ  = 1000;
   localparam int HOUR_MAX = 23;
   localparam int SUB_W    = $clog2(TICK_HZ);
   localparam int DAY      = (HOUR_MAX + 1) * 3600 * TICK_HZ;

   logic clk = 1'b0;
   logic reset = 1'b1;

   watch_time_counter_if #(.TICK_HZ(TICK_HZ)) bus ();

   watch_time_counter #(.TICK_HZ(TICK_HZ), .HOUR_MAX(HOUR_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int m_total = 0;
   int cnt_sec = 0;
   int cnt_min = 0;
   int cnt_exp = 0;
   int cnt_err = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input int h, input int m, input int s, input int sub,
                                        input bit sp, input bit mp, input bit ex, input bit le);
      return 32'({5'(h), 6'(m), 6'(s), SUB_W'(sub), sp, mp, ex, le});
   endfunction

   function automatic logic [31:0] pack_total(input int t, input bit sp, input bit mp,
                                              input bit ex, input bit le);
      int secs;
      secs = t / TICK_HZ;
      return pack(secs / 3600, (secs / 60) % 60, secs % 60, t % TICK_HZ, sp, mp, ex, le);
   endfunction

   function automatic logic [31:0] dut_word();
      return 32'({bus.o_hour, bus.o_min, bus.o_sec, bus.o_sub,
                  bus.o_sec_pulse, bus.o_min_pulse, bus.o_expired, bus.o_load_err});
   endfunction

   // One clock cycle: drive inputs, advance the model, push, then compare after the edge.
   task automatic cyc(input string tag, input bit tick, input bit clr, input bit ld,
                      input int h = 0, input int m = 0, input int s = 0);
      bit sp, mp, ex, le;
      int old, hh, mm, ss;
      logic [31:0] got;
      @(negedge clk);
      bus.i_tick = tick;
      bus.i_clear = clr;
      bus.i_load = ld;
      bus.i_hour_val = 5'(h);
      bus.i_min_val = 6'(m);
      bus.i_sec_val = 6'(s);
      sp = 0; mp = 0; ex = 0; le = 0;
      if (clr) begin
         m_total = 0;
      end else if (ld) begin
         hh = (h > HOUR_MAX) ? HOUR_MAX : h;
         mm = (m > 59) ? 59 : m;
         ss = (s > 59) ? 59 : s;
         le = (h > HOUR_MAX) || (m > 59) || (s > 59);
         m_total = ((hh * 60 + mm) * 60 + ss) * TICK_HZ;
      end else if (tick && bus.i_run) begin
         old = m_total;
         if (!bus.i_down) begin
            m_total = (old + 1) % DAY;
            sp = (m_total % TICK_HZ) == 0;
            mp = (m_total % (60 * TICK_HZ)) == 0;
         end else if (old != 0) begin
            m_total = old - 1;
            sp = (old % TICK_HZ) == 0;
            mp = (old % (60 * TICK_HZ)) == 0;
            ex = (m_total == 0);
         end
      end
      exp_q.push_back(pack_total(m_total, sp, mp, ex, le));
      @(posedge clk);
      #1;
      got = dut_word();
      cnt_sec += int'(bus.o_sec_pulse);
      cnt_min += int'(bus.o_min_pulse);
      cnt_exp += int'(bus.o_expired);
      cnt_err += int'(bus.o_load_err);
      check(tag, got, exp_q.pop_front());
      bus.i_tick = 1'b0;
      bus.i_clear = 1'b0;
      bus.i_load = 1'b0;
   endtask

   task automatic clear_counts();
      cnt_sec = 0; cnt_min = 0; cnt_exp = 0; cnt_err = 0;
   endtask

   initial begin
      bus.i_tick = 0; bus.i_run = 0; bus.i_down = 0; bus.i_clear = 0; bus.i_load = 0;
      bus.i_hour_val = '0; bus.i_min_val = '0; bus.i_sec_val = '0;

      #3;
      check("reset_state", dut_word(), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // 1000 up ticks: one second elapses, a single sec strobe on the last tick.
      bus.i_run = 1; bus.i_down = 0;
      clear_counts();
      for (int i = 0; i < TICK_HZ; i++) cyc("up_1s", 1, 0, 0);
      check("up_1s_final", dut_word(), pack(0, 0, 1, 0, 1, 0, 0, 0));
      check("up_1s_sec_pulses", 32'(cnt_sec), 32'd1);
      check("up_1s_min_pulses", 32'(cnt_min), 32'd0);

      // Day rollover from 23:59:59.999.
      cyc("load_235959", 0, 0, 1, 23, 59, 59);
      for (int i = 0; i < TICK_HZ - 1; i++) cyc("to_999", 1, 0, 0);
      check("at_999", dut_word(), pack(23, 59, 59, TICK_HZ - 1, 0, 0, 0, 0));
      cyc("day_wrap", 1, 0, 0);
      check("day_wrap_word", dut_word(), pack(0, 0, 0, 0, 1, 1, 0, 0));

      // Ticks while stopped are ignored.
      bus.i_run = 0;
      clear_counts();
      for (int i = 0; i < 50; i++) cyc("stopped", 1, 0, 0);
      check("stopped_pulses", 32'(cnt_sec + cnt_min), 32'd0);
      bus.i_run = 1;
      cyc("restart", 1, 0, 0);
      check("restart_sub1", dut_word(), pack(0, 0, 0, 1, 0, 0, 0, 0));

      // Countdown to expiry, then hold at zero.
      cyc("load_000001", 0, 0, 1, 0, 0, 1);
      bus.i_down = 1;
      clear_counts();
      for (int i = 0; i < TICK_HZ; i++) cyc("down_1s", 1, 0, 0);
      check("expired_word", dut_word(), pack(0, 0, 0, 0, 0, 0, 1, 0));
      check("expired_count", 32'(cnt_exp), 32'd1);
      clear_counts();
      for (int i = 0; i < 5; i++) cyc("zero_hold", 1, 0, 0);
      check("zero_hold_pulses", 32'(cnt_sec + cnt_min + cnt_exp), 32'd0);

      // Borrow across minute and hour, then count back up over the same boundary.
      cyc("load_010000", 0, 0, 1, 1, 0, 0);
      cyc("borrow_hour", 1, 0, 0);
      check("borrow_hour_word", dut_word(), pack(0, 59, 59, TICK_HZ - 1, 1, 1, 0, 0));
      bus.i_down = 0;
      cyc("carry_hour", 1, 0, 0);
      check("carry_hour_word", dut_word(), pack(1, 0, 0, 0, 1, 1, 0, 0));

      // Out-of-range load clamps and flags once.
      clear_counts();
      cyc("load_clamp", 0, 0, 1, 30, 61, 10);
      check("load_clamp_word", dut_word(), pack(23, 59, 10, 0, 0, 0, 0, 1));
      cyc("load_err_drop", 0, 0, 0);
      check("load_err_count", 32'(cnt_err), 32'd1);

      // Clear outranks load and tick in the same cycle.
      cyc("load_010203", 0, 0, 1, 1, 2, 3);
      cyc("clr_ld_tick", 1, 1, 1, 30, 61, 10);
      check("clr_priority_word", dut_word(), 32'h0);

      // Randomised mix of run/direction/load/clear.
      for (int i = 0; i < 400; i++) begin
         int r;
         bus.i_run  = ($urandom_range(0, 3) != 0);
         bus.i_down = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 99);
         if (r == 0)      cyc("rand_clear", 1, 1, 0);
         else if (r < 5)  cyc("rand_load", 1, 0, 1, $urandom_range(0, 31),
                              $urandom_range(0, 63), $urandom_range(0, 63));
         else             cyc("rand_tick", 1'($urandom_range(0, 1)), 0, 0);
      end

      // Asynchronous reset between clock edges.
      bus.i_run = 1; bus.i_down = 0;
      cyc("pre_reset_load", 0, 0, 1, 5, 6, 7);
      for (int i = 0; i < 3; i++) cyc("pre_reset_tick", 1, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", dut_word(), 32'h0);
      m_total = 0;
      @(negedge clk);
      reset = 1'b0;
      cyc("post_reset", 1, 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
